// File: rtl/song_memory_if.sv
// Song memory control bus.
// Groups the recorder/player handshake signals of song_memory so that the
// core and its users share one declaration.
//   master : recorder/player side (drives starts, notes, advance/stop)
//   slave  : song_memory core (drives note_out/note_valid/status)
// Optional: SONG_MEMORY_LOOP_EN adds play_loop (sampled with play_start).
interface song_memory_if #(
  parameter int NOTE_W = 10,
  parameter int DEPTH  = 128,
  parameter int SLOTS  = 4
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOT_W-1:0] slot_sel;
  logic              rec_start;
  logic              rec_valid;
  logic [NOTE_W-1:0] rec_note;
  logic              rec_stop;
  logic              play_start;
  logic              play_next;
  logic              play_stop;
`ifdef SONG_MEMORY_LOOP_EN
  logic              play_loop;
`endif
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              busy_rec;
  logic              busy_play;
  logic              full;
  logic              done;
  logic [ADDR_W:0]   cur_len;

  modport master (
    output slot_sel, rec_start, rec_valid, rec_note, rec_stop,
    output play_start, play_next, play_stop,
`ifdef SONG_MEMORY_LOOP_EN
    output play_loop,
`endif
    input  note_out, note_valid, busy_rec, busy_play, full, done, cur_len
  );

  modport slave (
    input  slot_sel, rec_start, rec_valid, rec_note, rec_stop,
    input  play_start, play_next, play_stop,
`ifdef SONG_MEMORY_LOOP_EN
    input  play_loop,
`endif
    output note_out, note_valid, busy_rec, busy_play, full, done, cur_len
  );
endinterface

// File: rtl/song_memory.sv
// Multi-slot song note store for the piano.
// SLOTS songs of up to DEPTH notes (NOTE_W bits each) in one synchronous RAM
// addressed as {slot, ptr}. Record mode appends notes; playback presents one
// note at a time under a play_next / play_stop handshake.
// Ports:
//   clk  - rising-edge system clock
//   rst  - asynchronous active-high reset
//   bus  - song_memory_if.slave (record/playback controls, note output,
//          busy/full/done status, cur_len of the latched slot)
// Optional: define SONG_MEMORY_LOOP_EN to enable looped playback (play_loop).
module song_memory #(
  parameter int NOTE_W = 10,
  parameter int DEPTH  = 128,
  parameter int SLOTS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  song_memory_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REC, PLAY_RD, PLAY_HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W:0]     len_q [SLOTS];
  logic [ADDR_W:0]     ptr_inc;
  logic [ADDR_W:0]     len_cur;
  logic                wr_en, rd_en, clr_len;
  logic                done_d, done_q, full_d, full_q;
  logic                has_data_q;
  logic [NOTE_W-1:0]   mem [SLOTS*DEPTH];
  logic [NOTE_W-1:0]   rd_data;
`ifdef SONG_MEMORY_LOOP_EN
  logic                loop_q, loop_d;
`endif

  assign ptr_inc = {1'b0, ptr_q} + (ADDR_W+1)'(1);
  assign len_cur = len_q[slot_q];

  // State register and per-slot bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      slot_q     <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      has_data_q <= 1'b0;
      for (int s = 0; s < SLOTS; s++) len_q[s] <= '0;
`ifdef SONG_MEMORY_LOOP_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      full_q  <= full_d;
      if (rd_en)   has_data_q    <= 1'b1;
      if (clr_len) len_q[slot_d] <= '0;
      if (wr_en)   len_q[slot_q] <= ptr_inc;
`ifdef SONG_MEMORY_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  // Next-state and control strobes.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_len = 1'b0;
    done_d  = 1'b0;
    full_d  = 1'b0;
`ifdef SONG_MEMORY_LOOP_EN
    loop_d  = loop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.rec_start) begin
          slot_d  = bus.slot_sel;
          ptr_d   = '0;
          clr_len = 1'b1;
          state_d = REC;
        end else if (bus.play_start) begin
          if (len_q[bus.slot_sel] == '0) begin
            done_d = 1'b1;
          end else begin
            slot_d  = bus.slot_sel;
            ptr_d   = '0;
            state_d = PLAY_RD;
`ifdef SONG_MEMORY_LOOP_EN
            loop_d  = bus.play_loop;
`endif
          end
        end
      end
      REC: begin
        if (bus.rec_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          // The DEPTH-th note ends the recording on its own.
          if (ptr_q == PTR_LAST) begin
            full_d  = 1'b1;
            state_d = IDLE;
          end
        end
        if (bus.rec_stop) state_d = IDLE;
      end
      PLAY_RD: begin
        // Suppress the read on abort so note_out keeps the last shown note.
        if (bus.play_stop) begin
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          state_d = PLAY_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (bus.play_stop) begin
          state_d = IDLE;
        end else if (bus.play_next) begin
          if (ptr_inc < len_cur) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = PLAY_RD;
          end else begin
            done_d  = 1'b1;
`ifdef SONG_MEMORY_LOOP_EN
            if (loop_q) begin
              ptr_d   = '0;
              state_d = PLAY_RD;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Note RAM: one port, synchronous read.
  // NOTE: the array has no reset so it maps onto block RAM; validity is
  // carried by the reset length registers and has_data_q instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{slot_q, ptr_q}] <= bus.rec_note;
    if (rd_en) rd_data <= mem[{slot_q, ptr_q}];
  end

  // Outputs.
  always_comb begin
    bus.note_out   = has_data_q ? rd_data : '0;
    bus.note_valid = (state_q == PLAY_HOLD);
    bus.busy_rec   = (state_q == REC);
    bus.busy_play  = (state_q == PLAY_RD) || (state_q == PLAY_HOLD);
    bus.full       = full_q;
    bus.done       = done_q;
    bus.cur_len    = len_cur;
  end
endmodule

// File: tb/tb_song_memory.sv
// Self-checking bench for song_memory: a per-slot reference model feeds an
// expected-note queue at play_start; notes are popped as the DUT shows them.
module tb_song_memory;
  localparam int NOTE_W = 10;
  localparam int DEPTH  = 128;
  localparam int SLOTS  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [NOTE_W-1:0] model_mem [SLOTS][DEPTH];
  int                model_len [SLOTS];
  logic [NOTE_W-1:0] exp_q [$];
  logic [NOTE_W-1:0] stim_q [$];

  song_memory_if #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .SLOTS(SLOTS)) bus ();

  song_memory #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .SLOTS(SLOTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_note(input string tag);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 1, 0);
    else check(tag, 32'(bus.note_out), 32'(exp_q.pop_front()));
  endtask

  // Record stim_q into slot s, ending with rec_stop.
  task automatic record(input int s);
    bus.slot_sel  = 2'(s);
    bus.rec_start = 1'b1;
    tick();
    bus.rec_start = 1'b0;
    check("rec_busy", 32'(bus.busy_rec), 1);
    model_len[s] = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      bus.rec_valid = 1'b1;
      bus.rec_note  = stim_q[i];
      model_mem[s][i] = stim_q[i];
      model_len[s]    = i + 1;
      tick();
    end
    bus.rec_valid = 1'b0;
    bus.rec_stop  = 1'b1;
    tick();
    bus.rec_stop  = 1'b0;
    check("rec_idle", 32'(bus.busy_rec), 0);
    check("rec_len", 32'(bus.cur_len), 32'(model_len[s]));
  endtask

  // Play slot s to its natural end, checking latency, gaps and done.
  task automatic play(input int s);
    for (int i = 0; i < model_len[s]; i++) exp_q.push_back(model_mem[s][i]);
    bus.slot_sel   = 2'(s);
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
    check("lat_rd", 32'(bus.note_valid), 0);
    tick();
    for (int i = 0; i < model_len[s]; i++) begin
      check("play_valid", 32'(bus.note_valid), 1);
      check_note("play_note");
      bus.play_next = 1'b1;
      tick();
      bus.play_next = 1'b0;
      if (i == model_len[s] - 1) begin
        check("end_done", 32'(bus.done), 1);
        check("end_valid", 32'(bus.note_valid), 0);
        check("end_busy", 32'(bus.busy_play), 0);
        tick();
        check("end_done_pulse", 32'(bus.done), 0);
      end else begin
        check("gap_valid", 32'(bus.note_valid), 0);
        check("gap_done", 32'(bus.done), 0);
        tick();
      end
    end
    check("play_sb_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.slot_sel   = '0;
    bus.rec_start  = 1'b0;
    bus.rec_valid  = 1'b0;
    bus.rec_note   = '0;
    bus.rec_stop   = 1'b0;
    bus.play_start = 1'b0;
    bus.play_next  = 1'b0;
    bus.play_stop  = 1'b0;
`ifdef SONG_MEMORY_LOOP_EN
    bus.play_loop  = 1'b0;
`endif
    for (int s = 0; s < SLOTS; s++) model_len[s] = 0;
    repeat (3) tick();
    check("rst_valid", 32'(bus.note_valid), 0);
    check("rst_note", 32'(bus.note_out), 0);
    check("rst_busy", {30'd0, bus.busy_rec, bus.busy_play}, 0);
    check("rst_flags", {30'd0, bus.full, bus.done}, 0);
    check("rst_len", 32'(bus.cur_len), 0);
    rst = 1'b0;
    tick();

    // Basic record/playback on slot 2.
    stim_q = '{10'h011, 10'h022, 10'h033};
    record(2);
    play(2);

    // Slot isolation.
    stim_q = '{10'h1AA};
    record(0);
    stim_q = '{10'h155};
    record(1);
    play(0);
    check("iso_len0", 32'(bus.cur_len), 1);
    play(1);
    check("iso_len1", 32'(bus.cur_len), 1);

    // Fill slot 0 to DEPTH; the extra write must be dropped.
    bus.slot_sel  = 2'd0;
    bus.rec_start = 1'b1;
    tick();
    bus.rec_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("full_early", 32'(bus.full), 0);
      bus.rec_valid = 1'b1;
      bus.rec_note  = NOTE_W'(i * 37 + 5);
      model_mem[0][i] = NOTE_W'(i * 37 + 5);
      tick();
    end
    model_len[0] = DEPTH;
    check("full_pulse", 32'(bus.full), 1);
    check("full_busy", 32'(bus.busy_rec), 0);
    check("full_len", 32'(bus.cur_len), DEPTH);
    bus.rec_note = 10'h3FF;
    tick();
    bus.rec_valid = 1'b0;
    check("full_once", 32'(bus.full), 0);
    check("full_len_after", 32'(bus.cur_len), DEPTH);
    play(0);

    // Empty slot 3: immediate done, no playback.
    bus.slot_sel   = 2'd3;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
    check("empty_done", 32'(bus.done), 1);
    check("empty_valid", 32'(bus.note_valid), 0);
    check("empty_busy", 32'(bus.busy_play), 0);
    tick();
    check("empty_done_pulse", 32'(bus.done), 0);
    check("empty_valid2", 32'(bus.note_valid), 0);

    // rec_start beats play_start (slot 2 has notes).
    bus.slot_sel   = 2'd2;
    bus.rec_start  = 1'b1;
    bus.play_start = 1'b1;
    tick();
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    check("prio_rec", 32'(bus.busy_rec), 1);
    check("prio_play", 32'(bus.busy_play), 0);
    check("prio_len", 32'(bus.cur_len), 0);
    stim_q = '{10'h011, 10'h022, 10'h033};
    for (int i = 0; i < 3; i++) begin
      bus.rec_valid = 1'b1;
      bus.rec_note  = stim_q[i];
      model_mem[2][i] = stim_q[i];
      tick();
    end
    model_len[2] = 3;
    bus.rec_valid = 1'b0;
    bus.rec_stop  = 1'b1;
    tick();
    bus.rec_stop  = 1'b0;
    check("prio_len3", 32'(bus.cur_len), 3);

    // Abort during note 2 of 3; play_stop outranks play_next.
    for (int i = 0; i < 2; i++) exp_q.push_back(model_mem[2][i]);
    bus.slot_sel   = 2'd2;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
    tick();
    check_note("abort_note1");
    bus.play_next = 1'b1;
    tick();
    bus.play_next = 1'b0;
    tick();
    check("abort_valid2", 32'(bus.note_valid), 1);
    check_note("abort_note2");
    bus.play_stop = 1'b1;
    bus.play_next = 1'b1;
    tick();
    bus.play_stop = 1'b0;
    bus.play_next = 1'b0;
    check("abort_busy", 32'(bus.busy_play), 0);
    check("abort_valid", 32'(bus.note_valid), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_hold", 32'(bus.note_out), 32'h022);
    tick();
    check("abort_done2", 32'(bus.done), 0);

    // Async reset during REC after two writes, between clock edges.
    bus.slot_sel  = 2'd1;
    bus.rec_start = 1'b1;
    tick();
    bus.rec_start = 1'b0;
    bus.rec_valid = 1'b1;
    bus.rec_note  = 10'h0AB;
    tick();
    tick();
    bus.rec_valid = 1'b0;
    check("arst_pre_len", 32'(bus.cur_len), 2);
    #2;
    rst = 1'b1;
    #1;
    for (int s = 0; s < SLOTS; s++) model_len[s] = 0;
    check("arst_len", 32'(bus.cur_len), 0);
    check("arst_busy", {30'd0, bus.busy_rec, bus.busy_play}, 0);
    check("arst_valid", 32'(bus.note_valid), 0);
    check("arst_note", 32'(bus.note_out), 0);
    check("arst_flags", {30'd0, bus.full, bus.done}, 0);
    tick();
    rst = 1'b0;
    tick();
    bus.slot_sel   = 2'd1;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
    check("arst_slot_empty", 32'(bus.done), 1);

`ifdef SONG_MEMORY_LOOP_EN
    // Looped 2-note song: wraps with a done pulse each time until play_stop.
    stim_q = '{10'h011, 10'h022};
    record(0);
    for (int k = 0; k < 5; k++) exp_q.push_back(model_mem[0][k % 2]);
    bus.slot_sel   = 2'd0;
    bus.play_loop  = 1'b1;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
    bus.play_loop  = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("loop_valid", 32'(bus.note_valid), 1);
      check_note("loop_note");
      bus.play_next = 1'b1;
      tick();
      bus.play_next = 1'b0;
      check("loop_done", 32'(bus.done), (k % 2 == 1) ? 1 : 0);
      check("loop_busy", 32'(bus.busy_play), 1);
      tick();
    end
    check_note("loop_note_last");
    bus.play_stop = 1'b1;
    tick();
    bus.play_stop = 1'b0;
    check("loop_stop_busy", 32'(bus.busy_play), 0);
    check("loop_stop_done", 32'(bus.done), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
